// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the imem/dmem memory-port arbiter: request/response records,
// arbiter state encodings and the registered-state record.
package mem_port_arbiter_pkg;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_spec;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic [31:0] mem_rdata;
        logic        mem_ready;
    } mem_out_type;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IBUSY = 2'd1,
        ARB_DBUSY = 2'd2
    } arb_state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    typedef struct packed {
        arb_state_t  state;
        mem_in_type  req;
        logic        last_grant;
        logic [3:0]  starve_cnt;
    } arbiter_reg_type;

    localparam arbiter_reg_type init_arbiter_reg = '{
        state:      ARB_IDLE,
        req:        '0,
        last_grant: GRANT_I,
        starve_cnt: 4'd0
    };

    // Counts consecutive same-side grants taken while the other side waits.
    function automatic logic [3:0] starve_next(input logic [3:0] cnt,
                                               input logic [3:0] lim,
                                               input logic       extend);
        if (!extend)
            return 4'd0;
        if (cnt >= lim)
            return lim;
        return cnt + 4'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_slot.sv
// One pending-request slot: captures a full request record, newest capture wins,
// and empties when the arbiter grants it.
module mem_request_slot
    import mem_port_arbiter_pkg::*;
(
    input  logic       reset,
    input  logic       clock,
    input  logic       load,
    input  logic       clear,
    input  mem_in_type din,
    output mem_in_type dout,
    output logic       full
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            full <= 1'b0;
        else if (load)
            full <= 1'b1;
        else if (clear)
            full <= 1'b0;
    end

    // Payload needs no reset: it is only ever observed while full is set.
    always_ff @(posedge clock) begin
        if (load)
            dout <= din;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding memory port between fetch (imem) and load/store (dmem),
// issuing in IDLE with zero latency and routing each ready back to the owner only.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1,
    parameter int STARVE_MAX = 4
) (
    input  logic        reset,
    input  logic        clock,
    input  mem_in_type  imem_in,
    output mem_out_type imem_out,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out,
    output mem_in_type  mem_in,
    input  mem_out_type mem_out
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arbiter_reg_type r, v;
    mem_in_type      islot_q, dslot_q, isrc, dsrc;
    logic            ifull, dfull, ireq, dreq;
    logic            grant_i, grant_d, pick_d;

    mem_request_slot u_islot (
        .reset (reset),
        .clock (clock),
        .load  (imem_in.mem_valid && !grant_i),
        .clear (grant_i),
        .din   (imem_in),
        .dout  (islot_q),
        .full  (ifull)
    );

    mem_request_slot u_dslot (
        .reset (reset),
        .clock (clock),
        .load  (dmem_in.mem_valid && !grant_d),
        .clear (grant_d),
        .din   (dmem_in),
        .dout  (dslot_q),
        .full  (dfull)
    );

    always_comb begin
        v        = r;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        pick_d   = 1'b0;
        isrc     = imem_in.mem_valid ? imem_in : islot_q;
        dsrc     = dmem_in.mem_valid ? dmem_in : dslot_q;
        ireq     = imem_in.mem_valid || ifull;
        dreq     = dmem_in.mem_valid || dfull;

        mem_in             = r.req;
        mem_in.mem_valid   = 1'b0;
        imem_out.mem_rdata = mem_out.mem_rdata;
        dmem_out.mem_rdata = mem_out.mem_rdata;
        imem_out.mem_ready = 1'b0;
        dmem_out.mem_ready = 1'b0;

        case (r.state)
            ARB_IDLE: begin
                if (reset && (ireq || dreq)) begin
                    // At the starvation limit the side not granted last is the one waiting.
                    if (ireq && dreq)
                        pick_d = (r.starve_cnt == STARVE_LIM) ? (r.last_grant == GRANT_I)
                                                              : DATA_FIRST;
                    else
                        pick_d = dreq;

                    grant_d            = pick_d;
                    grant_i            = !pick_d;
                    v.req              = pick_d ? dsrc : isrc;
                    v.req.mem_valid    = 1'b0;
                    mem_in             = pick_d ? dsrc : isrc;
                    mem_in.mem_valid   = 1'b1;
                    v.starve_cnt       = starve_next(r.starve_cnt, STARVE_LIM,
                                                     (pick_d ? ireq : dreq) &&
                                                     (pick_d == r.last_grant));
                    v.last_grant       = pick_d;
                    v.state            = pick_d ? ARB_DBUSY : ARB_IBUSY;
                end
            end
            ARB_IBUSY: begin
                if (mem_out.mem_ready) begin
                    imem_out.mem_ready = 1'b1;
                    v.state            = ARB_IDLE;
                end
            end
            ARB_DBUSY: begin
                if (mem_out.mem_ready) begin
                    dmem_out.mem_ready = 1'b1;
                    v.state            = ARB_IDLE;
                end
            end
            default: v.state = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r <= init_arbiter_reg;
        else
            r <= v;
    end

    // The load/store unit must not issue again before its previous request was granted.
    dslot_overwrite: assert property (@(posedge clock) disable iff (!reset)
                                      !(dmem_in.mem_valid && dfull));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected issues/responses,
// monitors compare whatever the DUT presents on the shared port and both response ports.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    mem_in_type  imem_in, dmem_in, mem_in;
    mem_out_type imem_out, dmem_out, mem_out;

    logic        resp_ready = 1'b0, spur_ready = 1'b0;
    logic [31:0] resp_rdata = '0, spur_rdata = '0;
    int          lat = 2;

    assign mem_out.mem_ready = resp_ready | spur_ready;
    assign mem_out.mem_rdata = resp_ready ? resp_rdata : spur_rdata;

    mem_port_arbiter #(.DATA_FIRST(1'b1), .STARVE_MAX(2)) dut (
        .reset    (reset),
        .clock    (clock),
        .imem_in  (imem_in),
        .imem_out (imem_out),
        .dmem_in  (dmem_in),
        .dmem_out (dmem_out),
        .mem_in   (mem_in),
        .mem_out  (mem_out)
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] addr; logic instr; logic spec; } iss_t;
    typedef struct { logic side; logic [31:0] rdata; } rsp_t;
    iss_t exp_iss[$];
    rsp_t exp_rsp[$];
    iss_t mon_iss;
    rsp_t mon_rsp;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic mem_in_type mk(input logic instr, input logic [31:0] addr, input logic spec);
        mem_in_type m;
        m           = '0;
        m.mem_valid = 1'b1;
        m.mem_instr = instr;
        m.mem_spec  = spec;
        m.mem_addr  = addr;
        m.mem_wdata = addr + 32'h1;
        m.mem_wstrb = instr ? 4'h0 : 4'hF;
        return m;
    endfunction

    function automatic iss_t ei(input logic [31:0] a, input logic instr, input logic spec);
        iss_t e;
        e.addr = a; e.instr = instr; e.spec = spec;
        return e;
    endfunction

    function automatic rsp_t er(input logic side, input logic [31:0] d);
        rsp_t e;
        e.side = side; e.rdata = d;
        return e;
    endfunction

    // Issue monitor and response monitor
    always @(negedge clock) begin
        if (mem_in.mem_valid === 1'b1) begin
            if (exp_iss.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_issue: got addr %h expected no issue", mem_in.mem_addr);
            end else begin
                mon_iss = exp_iss.pop_front();
                check("issue_addr", mem_in.mem_addr, mon_iss.addr);
                check("issue_instr", 32'(mem_in.mem_instr), 32'(mon_iss.instr));
                check("issue_spec", 32'(mem_in.mem_spec), 32'(mon_iss.spec));
            end
        end
        if (imem_out.mem_ready === 1'b1 || dmem_out.mem_ready === 1'b1) begin
            check("single_owner_ready", 32'(imem_out.mem_ready & dmem_out.mem_ready), 32'd0);
            if (exp_rsp.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_response: got rdata %h expected no response", imem_out.mem_rdata);
            end else begin
                mon_rsp = exp_rsp.pop_front();
                check("resp_side", 32'(dmem_out.mem_ready), 32'(mon_rsp.side));
                check("resp_rdata", mon_rsp.side ? dmem_out.mem_rdata : imem_out.mem_rdata, mon_rsp.rdata);
            end
        end
    end

    // Memory model: answers each issue after lat cycles unless reset intervenes
    initial begin
        logic        aborted;
        logic [31:0] a;
        forever begin
            @(negedge clock);
            if (reset && mem_in.mem_valid) begin
                aborted = 1'b0;
                a = mem_in.mem_addr;
                repeat (lat) begin
                    @(posedge clock);
                    if (!reset) aborted = 1'b1;
                end
                if (!aborted) begin
                    #1 resp_ready = 1'b1;
                    resp_rdata = a ^ 32'hA5A5_0000;
                    @(posedge clock);
                    #1 resp_ready = 1'b0;
                    resp_rdata = '0;
                end
            end
        end
    end

    task automatic pulse(input logic d, input logic [31:0] addr, input logic spec);
        @(posedge clock); #1;
        if (d) dmem_in = mk(1'b0, addr, spec);
        else   imem_in = mk(1'b1, addr, spec);
        @(posedge clock); #1;
        imem_in = '0;
        dmem_in = '0;
    endtask

    task automatic pulse_both(input logic [31:0] ia, input logic [31:0] da);
        @(posedge clock); #1;
        imem_in = mk(1'b1, ia, 1'b0);
        dmem_in = mk(1'b0, da, 1'b0);
        @(posedge clock); #1;
        imem_in = '0;
        dmem_in = '0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_iss.size() != 0 || exp_rsp.size() != 0) && n < 200) begin
            @(posedge clock);
            n++;
        end
        check(name, 32'(exp_iss.size() + exp_rsp.size()), 32'd0);
        repeat (2) @(posedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        imem_in = '0;
        dmem_in = '0;

        // Reset state
        @(negedge clock);
        check("rst_mem_in", 32'(mem_in != '0), 32'd0);
        check("rst_imem_out", 32'(imem_out != '0), 32'd0);
        check("rst_dmem_out", 32'(dmem_out != '0), 32'd0);
        @(posedge clock); #1 reset = 1'b1;
        repeat (2) @(posedge clock);

        // 1: single fetch, zero-latency issue, ready routed to imem only
        lat = 2;
        exp_iss.push_back(ei(32'h100, 1'b1, 1'b0));
        exp_rsp.push_back(er(1'b0, 32'hA5A5_0100));
        @(posedge clock); #1 imem_in = mk(1'b1, 32'h100, 1'b0);
        #2 check("t1_zero_latency", 32'(mem_in.mem_valid), 32'd1);
        @(posedge clock); #1 imem_in = '0;
        drain("t1_drain");

        // 2: simultaneous requests, dmem first, imem one cycle after dmem ready
        exp_iss.push_back(ei(32'h8000, 1'b0, 1'b0));
        exp_iss.push_back(ei(32'h200, 1'b1, 1'b0));
        exp_rsp.push_back(er(1'b1, 32'hA5A5_8000));
        exp_rsp.push_back(er(1'b0, 32'hA5A5_0200));
        pulse_both(32'h200, 32'h8000);
        n = 0;
        do begin @(negedge clock); n++; end while (dmem_out.mem_ready !== 1'b1 && n < 20);
        @(negedge clock);
        check("t2_bubble_valid", 32'(mem_in.mem_valid), 32'd1);
        check("t2_bubble_addr", mem_in.mem_addr, 32'h200);
        drain("t2_drain");

        // 3: newest fetch overwrites the pending one during DBUSY
        lat = 4;
        exp_iss.push_back(ei(32'h8004, 1'b0, 1'b0));
        exp_iss.push_back(ei(32'h400, 1'b1, 1'b1));
        exp_rsp.push_back(er(1'b1, 32'hA5A5_8004));
        exp_rsp.push_back(er(1'b0, 32'hA5A5_0400));
        pulse(1'b1, 32'h8004, 1'b0);
        pulse(1'b0, 32'h300, 1'b0);
        pulse(1'b0, 32'h400, 1'b1);
        drain("t3_drain");

        // 4: starvation limit 2 forces imem after two dmem grants while it waits
        exp_iss.push_back(ei(32'h9000, 1'b0, 1'b0));
        exp_rsp.push_back(er(1'b1, 32'hA5A5_9000));
        pulse(1'b1, 32'h9000, 1'b0);
        drain("t4a_drain");
        exp_iss.push_back(ei(32'h9004, 1'b0, 1'b0));
        exp_iss.push_back(ei(32'h9008, 1'b0, 1'b0));
        exp_iss.push_back(ei(32'h500, 1'b1, 1'b0));
        exp_iss.push_back(ei(32'h900C, 1'b0, 1'b0));
        exp_rsp.push_back(er(1'b1, 32'hA5A5_9004));
        exp_rsp.push_back(er(1'b1, 32'hA5A5_9008));
        exp_rsp.push_back(er(1'b0, 32'hA5A5_0500));
        exp_rsp.push_back(er(1'b1, 32'hA5A5_900C));
        pulse_both(32'h500, 32'h9004);
        pulse(1'b1, 32'h9008, 1'b0);
        repeat (3) @(posedge clock);
        pulse(1'b1, 32'h900C, 1'b0);
        drain("t4b_drain");

        // 5: spurious ready in IDLE is dropped, rdata still broadcast
        @(posedge clock); #1;
        spur_ready = 1'b1;
        spur_rdata = 32'hDEADBEEF;
        @(negedge clock);
        check("t5_imem_ready", 32'(imem_out.mem_ready), 32'd0);
        check("t5_dmem_ready", 32'(dmem_out.mem_ready), 32'd0);
        check("t5_imem_rdata", imem_out.mem_rdata, 32'hDEADBEEF);
        check("t5_dmem_rdata", dmem_out.mem_rdata, 32'hDEADBEEF);
        @(posedge clock); #1;
        spur_ready = 1'b0;
        spur_rdata = '0;
        repeat (2) @(posedge clock);

        // 6: reset during IBUSY, then zero-latency fetch of address 0
        lat = 6;
        exp_iss.push_back(ei(32'h600, 1'b1, 1'b0));
        pulse(1'b0, 32'h600, 1'b0);
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check("t6_mem_in_zero", 32'(mem_in != '0), 32'd0);
        check("t6_imem_out_zero", 32'(imem_out != '0), 32'd0);
        @(negedge clock);
        check("t6_dmem_out_zero", 32'(dmem_out != '0), 32'd0);
        @(posedge clock); #1 reset = 1'b1;
        repeat (4) @(posedge clock);
        lat = 2;
        exp_iss.push_back(ei(32'h0, 1'b1, 1'b0));
        exp_rsp.push_back(er(1'b0, 32'hA5A5_0000));
        @(posedge clock); #1 imem_in = mk(1'b1, 32'h0, 1'b0);
        #2 check("t6_zero_latency", 32'(mem_in.mem_valid), 32'd1);
        @(posedge clock); #1 imem_in = '0;
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
